// File: rtl/alu_seq.sv
// alu_seq: issue/collect sequencer for the 2-cycle nibble-serial 8-bit ALU.
// Aligns issue to the ALU phase, holds operands for both nibbles, captures result and ZNHC flags.
module alu_seq (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] flags_in,
    input  logic       alu_phase,
    input  logic [7:0] alu_out,
    input  logic [3:0] alu_flags,
    output logic [7:0] alu_in_A,
    output logic [7:0] alu_in_B,
    output logic [2:0] alu_op,
    output logic       alu_in_C,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [3:0] flags_out,
    output logic       wb_en,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    // Handshake: start is sampled on a posedge only while busy=0 (IDLE); the
    // operation is latched there and busy rises the next cycle. done is a
    // one-cycle valid for result/flags_out; no back-pressure, no queueing.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       accept;
    logic       is_sub;
    logic       h_fin;
    logic       c_fin;
    logic [3:0] flags_d;
    logic       unused_bits;

    assign unused_bits = ^{flags_in[3:1], alu_flags[2]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issuing in a high-phase cycle means the next cycle is already the low
    // phase; otherwise one ALIGN cycle is spent to line up with the ALU.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = alu_phase ? S_LOW : S_ALIGN;
                end
            end
            S_ALIGN: state_d = S_LOW;
            S_LOW:   state_d = S_HIGH;
            S_HIGH:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand registers only move on acceptance, so the ALU sees stable
    // inputs through both nibble phases and the DONE cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_in_A <= 8'h00;
            alu_in_B <= 8'h00;
            alu_op   <= 3'd0;
            alu_in_C <= 1'b0;
        end else if (accept) begin
            alu_in_A <= a;
            alu_in_B <= b;
            alu_op   <= op;
            alu_in_C <= flags_in[0];
        end
    end

    // Raw ALU carries are borrows for subtracting ops and pass straight through.
    always_comb begin
        is_sub = 1'b0;
        h_fin  = alu_flags[1];
        c_fin  = alu_flags[0];
        case (alu_op)
            OP_SUB, OP_SBC, OP_CP: is_sub = 1'b1;
            OP_AND: begin
                h_fin = 1'b1;
                c_fin = 1'b0;
            end
            OP_XOR, OP_OR: begin
                h_fin = 1'b0;
                c_fin = 1'b0;
            end
            default: begin
                h_fin = alu_flags[1];
                c_fin = alu_flags[0];
            end
        endcase
        flags_d = {alu_flags[3], is_sub, h_fin, c_fin};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result    <= 8'h00;
            flags_out <= 4'h0;
        end else if (state_q == S_HIGH) begin
            result    <= alu_out;
            flags_out <= flags_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign wb_en     = done && (alu_op != OP_CP);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a nibble-serial ALU environment model plus whole-operation
// arithmetic reference, with directed, random, back-to-back and reset scenarios.
module tb_alu_seq;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [3:0] flags_in = 4'h0;
    logic       alu_phase = 1'b0;
    logic [7:0] alu_out;
    logic [3:0] alu_flags;
    logic [7:0] alu_in_A;
    logic [7:0] alu_in_B;
    logic [2:0] alu_op;
    logic       alu_in_C;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [3:0] flags_out;
    logic       wb_en;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flags_in  (flags_in),
        .alu_phase (alu_phase),
        .alu_out   (alu_out),
        .alu_flags (alu_flags),
        .alu_in_A  (alu_in_A),
        .alu_in_B  (alu_in_B),
        .alu_op    (alu_op),
        .alu_in_C  (alu_in_C),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .flags_out (flags_out),
        .wb_en     (wb_en),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    // ---------------- nibble-serial ALU environment ----------------
    function automatic logic [4:0] nib(input logic [2:0] o, input logic [3:0] x,
                                       input logic [3:0] y, input logic ci);
        logic [4:0] r;
        case (o)
            3'd0, 3'd1:       r = {1'b0, x} + {1'b0, y} + {4'b0, ci};
            3'd2, 3'd3, 3'd7: r = {1'b0, x} - {1'b0, y} - {4'b0, ci};
            3'd4:             r = {1'b0, x & y};
            3'd5:             r = {1'b0, x ^ y};
            default:          r = {1'b0, x | y};
        endcase
        return r;
    endfunction

    logic [4:0] lo_q = 5'd0;
    logic [4:0] hi;
    logic       cin_lo;
    logic       is_log;

    always_comb begin
        is_log    = (alu_op == 3'd4) || (alu_op == 3'd5) || (alu_op == 3'd6);
        cin_lo    = ((alu_op == 3'd1) || (alu_op == 3'd3)) ? alu_in_C : 1'b0;
        hi        = nib(alu_op, alu_in_A[7:4], alu_in_B[7:4], is_log ? 1'b0 : lo_q[4]);
        alu_out   = {hi[3:0], lo_q[3:0]};
        // Logic ops present deliberately wrong raw H/C so the sequencer's override shows.
        alu_flags = {({hi[3:0], lo_q[3:0]} == 8'h00), 1'b0,
                     is_log ? (alu_op != 3'd4) : lo_q[4],
                     is_log ? 1'b1 : hi[4]};
    end

    always @(posedge clock) begin
        alu_phase <= ~alu_phase;
        if (!alu_phase) lo_q <= nib(alu_op, alu_in_A[3:0], alu_in_B[3:0], cin_lo);
    end

    // ---------------- reference model: {Z,N,H,C, result} ----------------
    function automatic logic [11:0] ref_op(input int o, input int x, input int y, input int cin);
        int   ci;
        int   r;
        logic z, n, h, c;
        ci = (o == 1 || o == 3) ? cin : 0;
        n = 1'b0;
        h = 1'b0;
        c = 1'b0;
        case (o)
            0, 1: begin
                r = x + y + ci;
                h = ((x % 16) + (y % 16) + ci) > 15;
                c = r > 255;
            end
            2, 3, 7: begin
                r = x - y - ci;
                n = 1'b1;
                h = (x % 16) < ((y % 16) + ci);
                c = x < (y + ci);
            end
            4: begin
                r = x & y;
                h = 1'b1;
            end
            5:       r = x ^ y;
            default: r = x | y;
        endcase
        r = r & 255;
        z = (r == 0);
        return {z, n, h, c, r[7:0]};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if ({busy, done, wb_en, result, flags_out, alu_in_A, alu_in_B, alu_op, alu_in_C} !== 35'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected 0",
                     {busy, done, wb_en, result, flags_out, alu_in_A, alu_in_B, alu_op, alu_in_C});
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        n_cmp++;
        if ({busy, done, wb_en} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release_idle: got %b expected 000", {busy, done, wb_en});
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic cin, input logic ph);
        logic [11:0] exp;
        int          n;
        exp = ref_op(o, x, y, cin);
        for (int i = 0; i < 4 && alu_phase !== ph; i++) begin
            @(posedge clock);
            #1;
        end
        op       = o;
        a        = x;
        b        = y;
        flags_in = 4'($urandom_range(0, 15));
        flags_in[0] = cin;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_accept: got %b expected 1", name, busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 8) begin
            n_cmp++;
            if ({alu_in_A, alu_in_B, alu_op, alu_in_C} !== {x, y, o, cin}) begin
                n_err++;
                $display("FAIL %s operand_hold: got %h expected %h", name,
                         {alu_in_A, alu_in_B, alu_op, alu_in_C}, {x, y, o, cin});
            end
            a        = 8'($urandom);
            b        = 8'($urandom);
            op       = 3'($urandom);
            flags_in = 4'($urandom);
            start    = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            n++;
        end
        n_cmp++;
        if (n !== (ph ? 2 : 3)) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges expected %0d", name, n, ph ? 2 : 3);
        end
        n_cmp++;
        if ({result, flags_out, wb_en} !== {exp[7:0], exp[11:8], o != 3'd7}) begin
            n_err++;
            $display("FAIL %s result/flags/wb_en: got %h/%b/%b expected %h/%b/%b", name,
                     result, flags_out, wb_en, exp[7:0], exp[11:8], o != 3'd7);
        end
        n_cmp++;
        if ({alu_in_A, alu_in_B, alu_op, alu_in_C} !== {x, y, o, cin}) begin
            n_err++;
            $display("FAIL %s operand_hold_done: got %h expected %h", name,
                     {alu_in_A, alu_in_B, alu_op, alu_in_C}, {x, y, o, cin});
        end
        // A request raised during DONE must not be taken.
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n_cmp++;
        if ({done, busy, wb_en} !== 3'b000) begin
            n_err++;
            $display("FAIL %s after_done_idle: got %b expected 000", name, {done, busy, wb_en});
        end
    endtask

    task automatic test_directed;
        run_op("add_3a_c6", 3'd0, 8'h3A, 8'hC6, 1'b0, 1'b1);
        run_op("adc_e1_0f", 3'd1, 8'hE1, 8'h0F, 1'b1, 1'b0);
        run_op("sub_3e_3e", 3'd2, 8'h3E, 8'h3E, 1'b1, 1'($urandom_range(0, 1)));
        run_op("cp_3c_2f",  3'd7, 8'h3C, 8'h2F, 1'b0, 1'($urandom_range(0, 1)));
        run_op("and_5a_3f", 3'd4, 8'h5A, 8'h3F, 1'b0, 1'($urandom_range(0, 1)));
        run_op("xor_ff_ff", 3'd5, 8'hFF, 8'hFF, 1'b1, 1'($urandom_range(0, 1)));
        run_op("sbc_00_00", 3'd3, 8'h00, 8'h00, 1'b1, 1'b0);
        run_op("or_00_00",  3'd6, 8'h00, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            run_op("random", 3'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back;
        logic [12:0] exp_q[$];
        logic [12:0] e;
        logic [19:0] cur;
        int          busy_left;
        int          n_acc;
        int          n_done;
        busy_left = 0;
        n_acc     = 0;
        n_done    = 0;
        cur       = 20'd0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            n_cmp++;
            if ({busy, done} !== {busy_left > 0, busy_left == 1}) begin
                n_err++;
                $display("FAIL b2b_busy_done cyc %0d: got %b expected %b", cyc,
                         {busy, done}, {busy_left > 0, busy_left == 1});
            end
            if (busy_left > 0) begin
                n_cmp++;
                if ({alu_in_A, alu_in_B, alu_op, alu_in_C} !== cur) begin
                    n_err++;
                    $display("FAIL b2b_operand_hold cyc %0d: got %h expected %h", cyc,
                             {alu_in_A, alu_in_B, alu_op, alu_in_C}, cur);
                end
            end
            if (busy_left == 1 && done === 1'b1) begin
                n_done++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_scoreboard: got done expected empty queue");
                end else begin
                    e = exp_q.pop_front();
                    if ({wb_en, flags_out, result} !== e) begin
                        n_err++;
                        $display("FAIL b2b_result cyc %0d: got %h expected %h", cyc,
                                 {wb_en, flags_out, result}, e);
                    end
                end
            end
            start    = (cyc < 64);
            a        = 8'($urandom);
            b        = 8'($urandom);
            op       = 3'($urandom);
            flags_in = 4'($urandom);
            if (busy_left > 0) begin
                busy_left--;
            end else if (start) begin
                exp_q.push_back({op != 3'd7, ref_op(op, a, b, flags_in[0])});
                cur       = {a, b, op, flags_in[0]};
                busy_left = alu_phase ? 3 : 4;
                n_acc++;
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0 || n_done != n_acc || n_acc < 10) begin
            n_err++;
            $display("FAIL b2b_counts: got %0d done / %0d accepted / %0d pending expected all equal and >=10",
                     n_done, n_acc, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_op;
        run_op("pre_reset_add", 3'd0, 8'h3A, 8'hC6, 1'b0, 1'b1);
        for (int i = 0; i < 4 && alu_phase !== 1'b1; i++) begin
            @(posedge clock);
            #1;
        end
        op       = 3'd2;
        a        = 8'h90;
        b        = 8'h12;
        flags_in = 4'h0;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_op_busy: got %b expected 1", busy);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, wb_en, flags_out, result, alu_in_A} !== 23'd0) begin
            n_err++;
            $display("FAIL mid_op_reset: got %h expected 0",
                     {busy, done, wb_en, flags_out, result, alu_in_A});
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            n_cmp++;
            if ({busy, done, wb_en} !== 3'b000) begin
                n_err++;
                $display("FAIL post_reset_quiet cyc %0d: got %b expected 000", i, {busy, done, wb_en});
            end
        end
        run_op("post_reset_sbc", 3'd3, 8'h10, 8'h01, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Issue/collect sequencer for the 2-cycle nibble-serial 8-bit ALU. It drives the ALU inputs from the other end of that interface.
- Accepts one operation per start handshake and latches operands and carry-in.
- Aligns issue to the ALU's free-running low/high phase, holds operands stable for both phases, and captures the 8-bit result.
- Converts the ALU's raw {Z,0,Hc,C} flags into final Z N H C flags, with a write-back enable for the register file.

Parameters:
- none (widths fixed: 8-bit data, 3-bit op, 4-bit flags)

Ports:
- clock  in  1  system clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- op  in  3  0 add, 1 adc, 2 sub, 3 sbc, 4 and, 5 xor, 6 or, 7 cp
- a  in  8  operand A (accumulator)
- b  in  8  operand B
- flags_in  in  4  current F: {Z,N,H,C}; only C used
- alu_phase  in  1  ALU phase during the current cycle; 0=low nibble, 1=high nibble; toggles every cycle
- alu_out  in  8  ALU result {high nibble, latched low nibble}
- alu_flags  in  4  ALU flags {Z combined, 0, low-nibble carry, high-nibble carry}
- alu_in_A  out  8  operand A to ALU, held stable
- alu_in_B  out  8  operand B to ALU, held stable
- alu_op  out  3  op to ALU, held stable
- alu_in_C  out  1  carry-in to ALU (latched flags_in[0])
- busy  out  1  high from the cycle after acceptance through the DONE cycle
- done  out  1  one-cycle pulse; result and flags_out valid
- result  out  8  registered result
- flags_out  out  4  registered {Z,N,H,C}
- wb_en  out  1  equals done AND op!=cp

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; busy=0, done=0, wb_en=0.
  - result=8'h00, flags_out=4'h0.
  - operand registers (alu_in_A, alu_in_B, alu_op, alu_in_C) = 0.
  - Reset mid-operation aborts the operation: no done, no write-back.
- States: IDLE, ALIGN, LOW, HIGH, DONE.
- IDLE:
  - On posedge with start=1, latch a, b, op, flags_in[0] into the operand registers.
  - If alu_phase=1 in that cycle, next state is LOW (the next cycle is the low phase); else next state is ALIGN.
- ALIGN: one wait cycle, then LOW. This adds 1 cycle of latency.
- LOW: ALU evaluates the low nibble; go to HIGH.
- HIGH:
  - ALU evaluates the high nibble.
  - At the closing posedge, register alu_out into result and the computed flags into flags_out; go to DONE.
- DONE: done=1 and wb_en=(op!=cp) for exactly one cycle; return to IDLE.
- Latency: start accepted at edge k → done high in cycle k+2..k+3 when aligned, k+3..k+4 when not.
- Operand registers change only on acceptance and stay constant through DONE.
- Flag rules:
  - Z = alu_flags[3].
  - N = 1 for sub, sbc, cp; else 0.
  - H = alu_flags[1] for add/adc/sub/sbc/cp; 1 for and; 0 for xor/or.
  - C = alu_flags[0] for arithmetic and cp; 0 for logic ops.
  - For sub/sbc/cp, the ALU's carry bits are borrows and pass through unchanged.
- Boundary conditions:
  - start while busy=1: ignored, no queueing.
  - start in the DONE cycle: ignored. The earliest new acceptance is the first IDLE cycle.
  - cp: result is still registered, but wb_en stays 0 and flags_out is valid.
  - alu_phase is sampled only in IDLE. Misalignment after issue is a system error and is not checked.

Test Plan (bench drives alu_phase from the nibble ALU's phase via model or probe):
- add a=0x3A b=0xC6, accepted in phase 1 → done 2 edges later; result=0x00, flags_out=1011 (Z1 N0 H1 C1), wb_en=1.
- adc a=0xE1 b=0x0F flags_in C=1, accepted in phase 0 → ALIGN cycle, done 3 edges later; result=0xF1, flags_out=0010 (H1).
- sub a=0x3E b=0x3E → result=0x00, flags_out=1100; cp a=0x3C b=0x2F → flags_out=0110, wb_en=0 while done=1.
- and a=0x5A b=0x3F → result=0x1A, flags_out=0010; xor a=0xFF b=0xFF → result=0x00, flags_out=1000.
- start pulses held high continuously → accepted only in IDLE; one done per operation; operands do not change while busy.
- reset_n low during HIGH → busy, done and flags_out go to 0 immediately; no done after release; next start operates normally.
